// File: rtl/k12a_skip_ctrl.sv
// rtl/k12a_skip_ctrl.sv - conditional-skip sequencer for the K12A instruction word stream
// Optional build macro K12A_SKIP_STATS_EN adds the skipped_count output (saturating count of squashed instructions).

package k12a_skip_pkg;
  typedef enum logic [1:0] {
    SKIP_SEL_0                  = 2'd0,
    SKIP_SEL_CONDITION          = 2'd1,
    SKIP_SEL_CONDITION_INVERTED = 2'd2
  } skip_sel_t;
endpackage

module k12a_skip_ctrl
  import k12a_skip_pkg::*;
(
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [1:0] instr_len,
  input  logic       instr_is_skip,
  input  logic       instr_invert,
  input  logic       flush,
  input  logic       skip,
  output skip_sel_t  skip_sel,
  output logic       skip_store,
  output logic       suppress,
  output logic       instr_done,
  output logic       busy
`ifdef K12A_SKIP_STATS_EN
  ,
  output logic [7:0] skipped_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_words_left;
  logic       r_is_skip;
  logic       r_invert;
  logic       r_busy;

  state_t     w_next_state;
  logic [1:0] w_next_words;
  logic       w_next_is_skip;
  logic       w_next_invert;
  logic [1:0] w_len_eff;
  logic       w_store;
  skip_sel_t  w_sel;
  logic       w_suppress;
  logic       w_done;
  logic       w_squash_hdr;

  // A zero length field still describes a one-word instruction.
  assign w_len_eff = (instr_len == 2'd0) ? 2'd1 : instr_len;

  // Next-state and zero-latency word outputs from the current state and this cycle's word.
  always_comb begin
    w_next_state   = r_state;
    w_next_words   = r_words_left;
    w_next_is_skip = r_is_skip;
    w_next_invert  = r_invert;
    w_store        = 1'b0;
    w_sel          = SKIP_SEL_0;
    w_suppress     = 1'b0;
    w_done         = 1'b0;
    w_squash_hdr   = 1'b0;
    if (flush) begin
      // Abort: drop the rest of the instruction and clear the skip flag.
      w_next_state = IDLE;
      w_next_words = 2'd0;
      w_store      = 1'b1;
    end else if (instr_valid) begin
      case (r_state)
        IDLE: begin
          if (skip) begin
            // Squashed header: consume the flag; its own condition is never evaluated.
            w_squash_hdr = 1'b1;
            w_suppress   = 1'b1;
            w_store      = 1'b1;
            if (w_len_eff == 2'd1) begin
              w_done = 1'b1;
            end else begin
              w_next_state = SQUASH;
              w_next_words = w_len_eff - 2'd1;
            end
          end else if (w_len_eff == 2'd1) begin
            w_done = 1'b1;
            if (instr_is_skip) begin
              w_store = 1'b1;
              w_sel   = instr_invert ? SKIP_SEL_CONDITION_INVERTED : SKIP_SEL_CONDITION;
            end
          end else begin
            w_next_state   = RUN;
            w_next_words   = w_len_eff - 2'd1;
            w_next_is_skip = instr_is_skip;
            w_next_invert  = instr_invert;
          end
        end
        RUN: begin
          w_next_words = r_words_left - 2'd1;
          if (r_words_left == 2'd1) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
            if (r_is_skip) begin
              w_store = 1'b1;
              w_sel   = r_invert ? SKIP_SEL_CONDITION_INVERTED : SKIP_SEL_CONDITION;
            end
          end
        end
        SQUASH: begin
          w_suppress   = 1'b1;
          w_next_words = r_words_left - 2'd1;
          if (r_words_left == 2'd1) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_words = 2'd0;
        end
      endcase
    end
  end

  // Outputs are held inactive while reset is asserted, whatever the inputs do.
  assign skip_store = reset_n & w_store;
  assign skip_sel   = reset_n ? w_sel : SKIP_SEL_0;
  assign suppress   = reset_n & w_suppress;
  assign instr_done = reset_n & w_done;
  assign busy       = r_busy;

  // Sequencer state, remaining-word counter, latched header flags and busy decode.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_words_left <= 2'd0;
      r_is_skip    <= 1'b0;
      r_invert     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_words_left <= w_next_words;
      r_is_skip    <= w_next_is_skip;
      r_invert     <= w_next_invert;
      r_busy       <= (w_next_state != IDLE);
    end
  end

`ifdef K12A_SKIP_STATS_EN
  logic [7:0] r_skipped_count;

  // Saturating count of squashed instruction headers.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_skipped_count <= 8'd0;
    end else if (w_squash_hdr && (r_skipped_count != 8'hFF)) begin
      r_skipped_count <= r_skipped_count + 8'd1;
    end
  end

  assign skipped_count = r_skipped_count;
`endif

endmodule

// File: tb/tb_k12a_skip_ctrl.sv
// tb/tb_k12a_skip_ctrl.sv - self-checking bench for k12a_skip_ctrl against an instruction-level model
module tb_k12a_skip_ctrl;
  import k12a_skip_pkg::*;

  logic       cpu_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [1:0] instr_len = 2'd0;
  logic       instr_is_skip = 1'b0;
  logic       instr_invert = 1'b0;
  logic       flush = 1'b0;
  logic       skip = 1'b0;
  skip_sel_t  skip_sel;
  logic       skip_store;
  logic       suppress;
  logic       instr_done;
  logic       busy;
`ifdef K12A_SKIP_STATS_EN
  logic [7:0] skipped_count;
  int         exp_count = 0;
`endif

  k12a_skip_ctrl dut (
    .cpu_clock     (cpu_clock),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr_len     (instr_len),
    .instr_is_skip (instr_is_skip),
    .instr_invert  (instr_invert),
    .flush         (flush),
    .skip          (skip),
    .skip_sel      (skip_sel),
    .skip_store    (skip_store),
    .suppress      (suppress),
    .instr_done    (instr_done),
    .busy          (busy)
`ifdef K12A_SKIP_STATS_EN
    ,
    .skipped_count (skipped_count)
`endif
  );

  always #5 cpu_clock = ~cpu_clock;

  // Expected outputs for one word of an instruction.
  typedef struct packed {
    logic      store;
    skip_sel_t sel;
    logic      supp;
    logic      done;
  } word_exp_t;

  word_exp_t exp_q[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic v, input logic [1:0] len, input logic is_skip,
                      input logic inv, input logic fl, input logic sk);
    word_exp_t e;
    int        n;
    logic      squashed;
    @(negedge cpu_clock);
    instr_valid   = v;
    instr_len     = len;
    instr_is_skip = is_skip;
    instr_invert  = inv;
    flush         = fl;
    skip          = sk;
    #1;
    check("busy", 8'(busy), 8'(exp_q.size() != 0));
    e = '0;
    if (fl) begin
      e.store = 1'b1;
      exp_q.delete();
    end else if (v) begin
      if (exp_q.size() == 0) begin
        n = (len == 2'd0) ? 1 : int'(len);
        squashed = sk;
`ifdef K12A_SKIP_STATS_EN
        if (squashed && exp_count < 255) exp_count++;
`endif
        for (int k = 0; k < n; k++) begin
          word_exp_t w;
          w.supp  = squashed;
          w.done  = (k == n - 1);
          w.store = squashed ? (k == 0) : (is_skip && (k == n - 1));
          if (w.store && !squashed)
            w.sel = inv ? SKIP_SEL_CONDITION_INVERTED : SKIP_SEL_CONDITION;
          else
            w.sel = SKIP_SEL_0;
          exp_q.push_back(w);
        end
      end
      e = exp_q.pop_front();
    end
    check("skip_store", 8'(skip_store), 8'(e.store));
    check("skip_sel", 8'(skip_sel), 8'(e.sel));
    check("suppress", 8'(suppress), 8'(e.supp));
    check("instr_done", 8'(instr_done), 8'(e.done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_store"}, 8'(skip_store), 8'd0);
    check({tag, "_sel"}, 8'(skip_sel), 8'(SKIP_SEL_0));
    check({tag, "_supp"}, 8'(suppress), 8'd0);
    check({tag, "_done"}, 8'(instr_done), 8'd0);
  endtask

  initial begin
    // Reset state with a word presented: outputs must stay quiet.
    instr_valid = 1'b1;
    instr_is_skip = 1'b1;
    skip = 1'b1;
    instr_len = 2'd1;
    #3;
    check_reset_outputs("reset");
    @(negedge cpu_clock);
    instr_valid = 1'b0;
    reset_n = 1'b1;

    // Single-word skip, condition path, same-cycle store.
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t032_store", 8'(skip_store), 8'd1);
    check("t032_sel", 8'(skip_sel), 8'(SKIP_SEL_CONDITION));
    check("t032_done", 8'(instr_done), 8'd1);

    // Squashed three-word instruction.
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t033_hdr_supp", 8'(suppress), 8'd1);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t033_w2_busy", 8'(busy), 8'd1);
    check("t033_w2_store", 8'(skip_store), 8'd0);
    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t033_w3_done", 8'(instr_done), 8'd1);
    check("t033_w3_supp", 8'(suppress), 8'd1);

    // Two-word inverted skip: store on the last word only.
    step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t034_hdr_store", 8'(skip_store), 8'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t034_sel", 8'(skip_sel), 8'(SKIP_SEL_CONDITION_INVERTED));
    check("t034_done", 8'(instr_done), 8'd1);

    // Flush overrides a simultaneous word in RUN.
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t035_store", 8'(skip_store), 8'd1);
    check("t035_done", 8'(instr_done), 8'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t035_busy", 8'(busy), 8'd0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t035_hdr_done", 8'(instr_done), 8'd1);

    // Asynchronous reset mid-SQUASH with one word left.
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge cpu_clock);
    instr_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t036");
    exp_q.delete();
`ifdef K12A_SKIP_STATS_EN
    exp_count = 0;
`endif
    @(negedge cpu_clock);
    instr_valid = 1'b0;
    reset_n = 1'b1;
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t036_supp", 8'(suppress), 8'd0);
    check("t036_done", 8'(instr_done), 8'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));
`ifdef K12A_SKIP_STATS_EN
      check("rand_count", skipped_count, 8'(exp_count));
`endif
    end

`ifdef K12A_SKIP_STATS_EN
    // Saturation of the squash counter.
    for (int i = 0; i < 300; i++) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t037_count", skipped_count, 8'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/k12a_skip_ctrl.md
K12A_SKIP_CTRL -- requirements
Module: k12a_skip_ctrl

Interface
REQ-001 SHALL have ports: cpu_clock  in  1  CPU clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: instr_valid  in  1  one instruction word accepted this cycle.
REQ-004 SHALL have port: instr_len  in  2  word count of instruction; sampled on header word only.
REQ-005 SHALL have port: instr_is_skip  in  1  header is a conditional-skip instruction; sampled on header.
REQ-006 SHALL have port: instr_invert  in  1  skip on false condition; sampled on header.
REQ-007 SHALL have port: flush  in  1  synchronous abort of current instruction (branch/trap).
REQ-008 SHALL have port: skip  in  1  current skip-flag value.
REQ-009 SHALL have port: skip_sel  out  skip_sel_t  next-skip source for the skip flag.
REQ-010 SHALL have port: skip_store  out  1  write enable for the skip flag.
REQ-011 SHALL have port: suppress  out  1  current word belongs to a squashed instruction; kill side effects.
REQ-012 SHALL have port: instr_done  out  1  pulse on last word of any instruction, squashed or not.
REQ-013 SHALL have port: busy  out  1  instruction partially consumed (not in IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, SQUASH, plus 2-bit words_left counter.
REQ-015 SHALL treat instr_valid in IDLE as header word; instr_len 0 treated as 1.
REQ-016 Header with skip=0, len=1: instr_done=1, suppress=0, stay IDLE.
REQ-017 Header with skip=0, len>1: suppress=0, latch is_skip/invert, words_left=len-1, go RUN.
REQ-018 Header with skip=1: suppress=1, skip_store=1, skip_sel=SKIP_SEL_0 same cycle; len=1 -> instr_done=1, stay IDLE; else words_left=len-1, go SQUASH.
REQ-019 In RUN/SQUASH each instr_valid SHALL decrement words_left; suppress=1 on every word in SQUASH, 0 in RUN.
REQ-020 When words_left reaches 0 on a word, instr_done=1 that cycle, next state IDLE.
REQ-021 On last word of a non-squashed skip instruction: skip_store=1, skip_sel=SKIP_SEL_CONDITION (invert=0) or SKIP_SEL_CONDITION_INVERTED (invert=1); single-word skip does this on header cycle.
REQ-022 A squashed skip instruction SHALL NOT evaluate its condition (no chained skip).
REQ-023 skip_store SHALL be 0 in all cycles not listed in REQ-018/021/024; skip_sel=SKIP_SEL_0 when skip_store=0.
REQ-024 flush=1 SHALL force next state IDLE, words_left=0, skip_store=1 with SKIP_SEL_0, instr_done=0, suppress=0; flush overrides simultaneous instr_valid.
REQ-025 No instr_valid cycle SHALL leave state, counter and outputs unchanged except skip_store=0, instr_done=0, suppress=0.
REQ-026 skip_sel, skip_store, suppress, instr_done SHALL be combinational from state and inputs (zero latency); busy registered-state decode.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, words_left=0, latched flags 0.
REQ-028 During reset outputs SHALL be: skip_store=0, skip_sel=SKIP_SEL_0, suppress=0, instr_done=0, busy=0.
REQ-029 Reset mid-instruction SHALL discard remaining words; first valid after release is a header.

Configuration
REQ-030 Macro K12A_SKIP_STATS_EN defined: extra output skipped_count out 8, counts squashed instructions (increment on header with skip=1), saturates at 8'hFF, reset to 0.
REQ-031 Macro undefined: skipped_count port and counter absent; all other behaviour identical.

Verification
REQ-032 Header len=1, is_skip=1, invert=0, alu cond path, skip=0 -> same cycle skip_store=1, skip_sel=SKIP_SEL_CONDITION, instr_done=1.
REQ-033 skip=1, header len=3 then 2 valid words -> suppress=1 on all 3 words, skip_store=1/SKIP_SEL_0 on header only, instr_done on word 3, busy=1 between.
REQ-034 skip=0, header len=2 is_skip=1 invert=1 -> no store on header; word 2 skip_store=1, SKIP_SEL_CONDITION_INVERTED, instr_done=1.
REQ-035 Len=3 in RUN after word 2, flush=1 with instr_valid=1 -> skip_store=1/SKIP_SEL_0, instr_done=0, next cycle busy=0, next valid treated as header.
REQ-036 reset_n low while SQUASH with words_left=1 -> busy=0 immediately; after release header len=1 skip=0 -> suppress=0, instr_done=1.
REQ-037 With K12A_SKIP_STATS_EN: 300 squashed headers -> skipped_count=8'hFF; without macro, build has no skipped_count port.
